// File: rtl/riscv_lsu.sv
// RV32I load/store unit: decodes a load/store request, drives the data-memory
// grant/rvalid handshake and returns extended load data or an error response.
//
// state  | meaning
// IDLE   | ready for a request; access checked on acceptance
// REQ    | mem_req_o held with stable address/data/enables until granted
// WAIT_R | load granted, waiting for mem_rvalid_i
// RESP   | one-cycle rsp_valid_o pulse, then back to IDLE
module riscv_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state, state_nx;
    logic [2:0]      funct3_q, funct3_nx;
    logic [1:0]      off_q, off_nx;
    logic [CW-1:0]   tmo_cnt, tmo_cnt_nx;
    logic            mem_req_nx, mem_we_nx, rsp_valid_nx, rsp_err_nx;
    logic [3:0]      mem_be_nx;
    logic [XLEN-1:0] mem_addr_nx, mem_wdata_nx, rsp_rdata_nx;

    logic            misaligned, illegal, tmo_hit;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new, rshift, ld_data;

    assign req_ready_o = (state == IDLE);
    assign tmo_hit     = TMO_EN && (tmo_cnt == TMO_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_new     = 4'b0011 << {addr_i[1], 1'b0};
                wdata_new  = {2{wdata_i[15:0]}};
            end
            default: misaligned = (addr_i[1:0] != 2'b00);
        endcase
        if (is_store_i)
            illegal = (funct3_i >= 3'b011);
        else
            illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    end

    always_comb begin
        rshift = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ld_data = {24'b0, rshift[7:0]};
            3'b101:  ld_data = {16'b0, rshift[15:0]};
            default: ld_data = rshift;
        endcase
    end

    always_comb begin
        state_nx     = state;
        funct3_nx    = funct3_q;
        off_nx       = off_q;
        tmo_cnt_nx   = tmo_cnt;
        mem_req_nx   = mem_req_o;
        mem_we_nx    = mem_we_o;
        mem_be_nx    = mem_be_o;
        mem_addr_nx  = mem_addr_o;
        mem_wdata_nx = mem_wdata_o;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = '0;
        rsp_err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    funct3_nx = funct3_i;
                    off_nx    = addr_i[1:0];
                    if (misaligned || illegal) begin
                        state_nx     = RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                    end else begin
                        state_nx     = REQ;
                        tmo_cnt_nx   = '0;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = is_store_i;
                        mem_be_nx    = be_new;
                        mem_addr_nx  = {addr_i[XLEN-1:2], 2'b00};
                        mem_wdata_nx = wdata_new;
                    end
                end
            end
            REQ: begin
                // mem_we_o still holds the latched store/load direction here
                if (mem_gnt_i) begin
                    mem_req_nx = 1'b0;
                    if (mem_we_o) begin
                        state_nx     = RESP;
                        rsp_valid_nx = 1'b1;
                    end else begin
                        state_nx   = WAIT_R;
                        tmo_cnt_nx = '0;
                    end
                end else if (tmo_hit) begin
                    mem_req_nx   = 1'b0;
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else if (TMO_EN) begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_rdata_nx = ld_data;
                end else if (tmo_hit) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else if (TMO_EN) begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            tmo_cnt     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state       <= state_nx;
            funct3_q    <= funct3_nx;
            off_q       <= off_nx;
            tmo_cnt     <= tmo_cnt_nx;
            mem_req_o   <= mem_req_nx;
            mem_we_o    <= mem_we_nx;
            mem_be_o    <= mem_be_nx;
            mem_addr_o  <= mem_addr_nx;
            mem_wdata_o <= mem_wdata_nx;
            rsp_valid_o <= rsp_valid_nx;
            rsp_rdata_o <= rsp_rdata_nx;
            rsp_err_o   <= rsp_err_nx;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases plus random transactions
// against a byte-level reference model, with a cycle-accurate memory responder.
module tb_riscv_lsu;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    riscv_lsu #(.TIMEOUT_CYCLES(TMO), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and extension.
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((a % size_of(f3)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = size_of(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] v, mask;
        int n;
        n    = size_of(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (word >> (8 * (a % 4))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One full transaction starting at a negedge in IDLE; g/r are the 0-based
    // wait cycles before grant/rvalid (>= TMO means never).
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int g, input int r,
                           input logic [31:0] word, input bit noise,
                           output logic [3:0] o_be, output logic [31:0] o_wdata,
                           output logic [31:0] o_rdata, output logic o_err);
        bit exp_err, granted, got;
        exp_err = model_err(st, f3, a);
        granted = 1'b0;
        got     = 1'b0;
        o_be = '0; o_wdata = '0; o_rdata = '0; o_err = 1'b0;
        check1("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        if (exp_err) begin
            check1("err_valid", rsp_valid, 1'b1);
            check1("err_flag", rsp_err, 1'b1);
            check32("err_rdata", rsp_rdata, 32'h0);
            check1("err_no_req", mem_req, 1'b0);
            check1("err_not_ready", req_ready, 1'b0);
            o_err = rsp_err; o_rdata = rsp_rdata;
        end else begin
            for (int k = 0; k < TMO && !granted; k++) begin
                check1("req_high", mem_req, 1'b1);
                check1("req_we", mem_we, st);
                check32("req_be", {28'b0, mem_be}, {28'b0, model_be(f3, a)});
                check32("req_addr", mem_addr, a & 32'hFFFF_FFFC);
                if (st) check32("req_wdata", mem_wdata, model_wdata(f3, wd));
                check1("req_no_rsp", rsp_valid, 1'b0);
                o_be = mem_be; o_wdata = mem_wdata;
                mem_gnt    = (k == g);
                mem_rvalid = noise && (k != g) && ($urandom_range(0, 1) == 1);
                mem_rdata  = $urandom;
                @(negedge clk);
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                if (k == g) granted = 1'b1;
            end
            if (!granted) begin
                check1("tmo_req_low", mem_req, 1'b0);
                check1("tmo_valid", rsp_valid, 1'b1);
                check1("tmo_err", rsp_err, 1'b1);
                check32("tmo_rdata", rsp_rdata, 32'h0);
            end else if (st) begin
                check1("st_req_low", mem_req, 1'b0);
                check1("st_valid", rsp_valid, 1'b1);
                check1("st_err", rsp_err, 1'b0);
                check32("st_rdata", rsp_rdata, 32'h0);
            end else begin
                for (int j = 0; j < TMO && !got; j++) begin
                    check1("wr_req_low", mem_req, 1'b0);
                    check1("wr_no_rsp", rsp_valid, 1'b0);
                    mem_rvalid = (j == r);
                    mem_rdata  = (j == r) ? word : $urandom;
                    mem_gnt    = noise && ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    mem_rvalid = 1'b0; mem_gnt = 1'b0;
                    if (j == r) got = 1'b1;
                end
                check1("ld_valid", rsp_valid, 1'b1);
                if (got) begin
                    check1("ld_err", rsp_err, 1'b0);
                    check32("ld_rdata", rsp_rdata, model_load(f3, a, word));
                end else begin
                    check1("ld_tmo_err", rsp_err, 1'b1);
                    check32("ld_tmo_rdata", rsp_rdata, 32'h0);
                end
            end
            o_err = rsp_err; o_rdata = rsp_rdata;
        end
        @(negedge clk);
        check1("post_valid", rsp_valid, 1'b0);
        check32("post_rdata", rsp_rdata, 32'h0);
        check1("post_ready", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  be;
        logic [31:0] wd, rd, a;
        logic        er;
        logic [2:0]  f3;
        bit          st;

        #1 rst = 1'b1;
        #2;
        check1("rst_ready", req_ready, 1'b1);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_we", mem_we, 1'b0);
        check1("rst_valid", rsp_valid, 1'b0);
        check1("rst_err", rsp_err, 1'b0);
        check32("rst_be", {28'b0, mem_be}, 32'h0);
        check32("rst_addr", mem_addr, 32'h0);
        check32("rst_wdata", mem_wdata, 32'h0);
        check32("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h8000_0000, 1'b0, be, wd, rd, er);
        check32("lb_be", {28'b0, be}, 32'h8);
        check32("lb_rdata", rd, 32'hFFFF_FF80);
        check1("lb_err", er, 1'b0);

        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0, be, wd, rd, er);
        check32("sh_be", {28'b0, be}, 32'hC);
        check32("sh_wdata", wd, 32'hABCD_ABCD);
        check32("sh_rdata", rd, 32'h0);

        run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 0, 32'h0, 1'b0, be, wd, rd, er);
        check1("lw_mis_err", er, 1'b1);
        run_txn(1'b1, 3'b011, 32'h0000_0000, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0, be, wd, rd, er);
        check1("sw_ill_err", er, 1'b1);

        run_txn(1'b0, 3'b001, 32'h0000_0010, 32'h0, 3, 2, 32'h0000_F00D, 1'b0, be, wd, rd, er);
        check32("lh_rdata", rd, 32'hFFFF_F00D);
        run_txn(1'b0, 3'b101, 32'h0000_0010, 32'h0, 3, 2, 32'h0000_F00D, 1'b0, be, wd, rd, er);
        check32("lhu_rdata", rd, 32'h0000_F00D);

        run_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, 100, 0, 32'h0, 1'b0, be, wd, rd, er);
        check1("gnt_tmo_err", er, 1'b1);
        run_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, TMO - 1, 0, 32'hCAFE_F00D, 1'b0, be, wd, rd, er);
        check1("gnt_last_err", er, 1'b0);
        check32("gnt_last_rdata", rd, 32'hCAFE_F00D);
        run_txn(1'b0, 3'b000, 32'h0000_0021, 32'h0, 0, 100, 32'h0, 1'b0, be, wd, rd, er);
        check1("rv_tmo_err", er, 1'b1);
        run_txn(1'b0, 3'b100, 32'h0000_0022, 32'h0, 0, TMO - 1, 32'h0090_0000, 1'b0, be, wd, rd, er);
        check32("rv_last_rdata", rd, 32'h0000_0090);

        // reset while waiting for the grant
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080; wdata = 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        check1("rq_req_before", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check1("rq_rst_req", mem_req, 1'b0);
        check1("rq_rst_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset while waiting for read data; late rvalid must be ignored
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check1("wr_rst_req", mem_req, 1'b0);
        check1("wr_rst_ready", req_ready, 1'b1);
        check1("wr_rst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check1("late_rv_valid", rsp_valid, 1'b0);
        check1("late_rv_ready", req_ready, 1'b1);
        @(negedge clk);
        check1("late_rv_valid2", rsp_valid, 1'b0);

        run_txn(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 0, 0, 32'h0, 1'b0, be, wd, rd, er);
        check32("sb_be", {28'b0, be}, 32'h2);
        check32("sb_wdata", wd, 32'hA5A5_A5A5);
        check1("sb_err", er, 1'b0);

        for (int t = 0; t < 80; t++) begin
            st = ($urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
            run_txn(st, f3, a, $urandom, $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1),
                    $urandom, 1'b1, be, wd, rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
